// File: rtl/axis_pkt_fifo_if.sv
// AXI-stream beat bundle: data, end-of-packet, valid/ready handshake.
interface axis_pkt_fifo_if #(
    parameter int unsigned DW = 512
) ();
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tvalid;
    logic          tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-stream packet FIFO. A packet is released downstream only once its
// tlast beat is stored; a packet that fills the whole buffer without a tlast is released
// cut-through so the FIFO cannot deadlock.
module axis_pkt_fifo #(
    parameter int unsigned DW    = 512,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    axis_pkt_fifo_if.slave         axis_in,
    axis_pkt_fifo_if.master        axis_out,
    output logic [AW:0]            pkt_count,
    output logic                   oversize
);
    localparam logic [AW:0] Full = (AW+1)'(DEPTH);

    logic [DW:0]       mem [DEPTH];   // {tlast, tdata}
    logic [DW:0]       rd_data_q;

    // Pointers carry one extra wrap bit so equal pointers mean empty memory.
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;       // beats in memory + read stage + output
    logic [AW:0]       pkt_q, pkt_d;           // complete packets anywhere in the FIFO
    logic [AW:0]       mem_pkts_q, mem_pkts_d; // tlast beats still in memory, not yet read
    logic [DEPTH-1:0]  last_q, last_d;         // tlast shadow so the read side can count packets
    logic              in_ready_q, in_ready_d;
    logic              rd_valid_q, rd_valid_d;
    logic              out_valid_q, out_valid_d;
    logic [DW:0]       out_data_q, out_data_d;
    logic              forced_q, forced_d;     // held until the oversize packet's tlast leaves
    logic              frd_q, frd_d;           // read side open until that tlast is fetched
    logic              oversize_q, oversize_d;

    logic [AW-1:0]     wr_idx, rd_idx;
    logic              wr_en, wr_last, rd_en, rd_last, out_fire, out_load, out_last;
    logic              mem_empty, force_start;

    assign wr_idx      = wr_ptr_q[AW-1:0];
    assign rd_idx      = rd_ptr_q[AW-1:0];
    assign wr_en       = axis_in.tvalid & in_ready_q;
    assign wr_last     = wr_en & axis_in.tlast;
    assign out_fire    = out_valid_q & axis_out.tready;
    assign out_last    = out_fire & out_data_q[DW];
    assign out_load    = ~out_valid_q | axis_out.tready;
    assign mem_empty   = (wr_ptr_q == rd_ptr_q);
    // Fetch only beats of a fully stored packet, or any beat while a forced release is open.
    assign rd_en       = ~mem_empty & ((mem_pkts_q != '0) | frd_q) & (~rd_valid_q | out_load);
    assign rd_last     = rd_en & last_q[rd_idx];
    assign force_start = ~forced_q & (count_q == Full) & (pkt_q == '0);

    assign axis_in.tready  = in_ready_q;
    assign axis_out.tdata  = out_data_q[DW-1:0];
    assign axis_out.tlast  = out_data_q[DW];
    assign axis_out.tvalid = out_valid_q;
    assign pkt_count       = pkt_q;
    assign oversize        = oversize_q;

    // Next-state for pointers, counters, the two read stages and the forced-release flags.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, rd_en};
        last_d     = last_q;
        if (wr_en) begin
            last_d[wr_idx] = axis_in.tlast;
        end
        count_d    = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, out_fire};
        pkt_d      = pkt_q + {{AW{1'b0}}, wr_last} - {{AW{1'b0}}, out_last};
        mem_pkts_d = mem_pkts_q + {{AW{1'b0}}, wr_last} - {{AW{1'b0}}, rd_last};
        in_ready_d = (count_d < Full);
        rd_valid_d = rd_en | (rd_valid_q & ~out_load);

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (out_load) begin
            out_valid_d = rd_valid_q;
            if (rd_valid_q) begin
                out_data_d = rd_data_q;
            end
        end

        forced_d   = forced_q;
        frd_d      = frd_q;
        oversize_d = force_start;
        if (rd_last) begin
            frd_d = 1'b0;
        end
        if (forced_q & out_last) begin
            forced_d = 1'b0;
        end
        if (force_start) begin
            forced_d = 1'b1;
            frd_d    = 1'b1;
        end
    end

    // Control and output registers with synchronous reset; a partial packet is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pkt_q       <= '0;
            mem_pkts_q  <= '0;
            last_q      <= '0;
            in_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            forced_q    <= 1'b0;
            frd_q       <= 1'b0;
            oversize_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pkt_q       <= pkt_d;
            mem_pkts_q  <= mem_pkts_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            rd_valid_q  <= rd_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            forced_q    <= forced_d;
            frd_q       <= frd_d;
            oversize_q  <= oversize_d;
        end
    end

    // Beat storage: write port plus synchronous read into the first read stage.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= {axis_in.tlast, axis_in.tdata};
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_idx];
        end
    end
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: directed scenarios plus random traffic, checked against a
// queue-based packet model.
module tb_axis_pkt_fifo;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = $clog2(DEPTH);

    typedef struct packed {
        logic          l;
        logic [DW-1:0] d;
    } beat_t;

    logic          clk;
    logic          reset;
    logic [AW:0]   pkt_count;
    logic          oversize;

    axis_pkt_fifo_if #(.DW(DW)) in_if ();
    axis_pkt_fifo_if #(.DW(DW)) out_if ();

    axis_pkt_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .axis_in   (in_if),
        .axis_out  (out_if),
        .pkt_count (pkt_count),
        .oversize  (oversize)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    tests = 0;
    int    fails = 0;
    int    in_cnt = 0;
    int    out_cnt = 0;
    int    ovs_cnt = 0;
    bit    in_fired = 0;
    bit    m_forced = 0;
    bit    rst_prev = 1;
    bit    started = 0;
    bit    hold_v = 0;
    beat_t hold_b;
    beat_t exp_q[$];   // beats accepted and not yet delivered, in order
    beat_t src_q[$];   // beats waiting to be offered

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int n_lasts();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i].l) n++;
        return n;
    endfunction

    // One clock: check current outputs against the model, advance the model, then clock.
    task automatic step();
        beat_t ob;
        int    nl;
        bit    ofire;
        bit    exp_ovs;
        ob.d = out_if.tdata;
        ob.l = out_if.tlast;
        nl   = n_lasts();
        if (started) begin
            check("in_tready", in_if.tready, (!rst_prev && exp_q.size() < DEPTH));
            if (hold_v) check("hold_stable", {out_if.tvalid, ob}, {1'b1, hold_b});
            if (out_if.tvalid === 1'b1) begin
                if (m_forced) check("no_underflow", exp_q.size() > 0, 1);
                else          check("store_fwd", nl > 0, 1);
            end
        end
        in_fired = !reset && in_if.tvalid && in_if.tready;
        ofire    = !reset && out_if.tvalid && out_if.tready;
        exp_ovs  = !reset && !m_forced && exp_q.size() == DEPTH && nl == 0;
        if (ofire) begin
            out_cnt++;
            if (exp_q.size() > 0) begin
                check("out_beat", ob, exp_q[0]);
                if (exp_q[0].l) m_forced = 0;
                void'(exp_q.pop_front());
            end
        end
        if (in_fired) begin
            in_cnt++;
            exp_q.push_back('{l: in_if.tlast, d: in_if.tdata});
        end
        if (exp_ovs) m_forced = 1;
        hold_v = !reset && out_if.tvalid && !out_if.tready;
        hold_b = ob;
        if (reset) begin
            exp_q.delete();
            m_forced = 0;
        end
        rst_prev = reset;
        @(posedge clk);
        #1;
        started = 1;
        check("oversize", oversize, exp_ovs);
        check("pkt_count", pkt_count, n_lasts());
        if (oversize === 1'b1) ovs_cnt++;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        int k = 0;
        in_if.tvalid = 1'b1;
        in_if.tdata  = d;
        in_if.tlast  = l;
        do begin
            step();
            k++;
        end while (!in_fired && k < 200);
        check("send_accepted", in_fired, 1);
        in_if.tvalid = 1'b0;
    endtask

    task automatic add_pkt(input int len);
        for (int i = 0; i < len; i++) src_q.push_back('{l: (i == len - 1), d: $urandom});
    endtask

    // Offer queued source beats; vp/rp are valid/ready percentages (rp < 0 keeps tready).
    task automatic pump(input int n, input int vp, input int rp);
        for (int i = 0; i < n; i++) begin
            if (rp >= 0) out_if.tready = ($urandom_range(99) < rp);
            in_if.tvalid = (src_q.size() > 0) && ($urandom_range(99) < vp);
            if (src_q.size() > 0) begin
                in_if.tdata = src_q[0].d;
                in_if.tlast = src_q[0].l;
            end
            step();
            if (in_fired) void'(src_q.pop_front());
        end
        in_if.tvalid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        in_if.tvalid  = 1'b0;
        out_if.tready = 1'b1;
        while (exp_q.size() > 0 && k < maxc) begin
            step();
            k++;
        end
        check("drain_empty", exp_q.size(), 0);
        check("drain_idle", out_if.tvalid, 0);
    endtask

    initial begin
        int k;
        reset         = 1'b1;
        in_if.tvalid  = 1'b0;
        in_if.tdata   = '0;
        in_if.tlast   = 1'b0;
        out_if.tready = 1'b0;
        step();
        step();
        check("rst_tvalid", out_if.tvalid, 0);
        check("rst_tlast", out_if.tlast, 0);
        check("rst_tdata", out_if.tdata, 0);
        check("rst_pkt", pkt_count, 0);
        check("rst_ovs", oversize, 0);
        check("rst_tready_in", in_if.tready, 0);
        reset = 1'b0;

        // 1: single 4-beat packet, exact 2-cycle release latency
        out_if.tready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send(DW'(i), i == 4);
            if (i < 4) check("t1_no_early", out_if.tvalid, 0);
        end
        check("t1_pkt1", pkt_count, 1);
        step();
        check("t1_lat1", out_if.tvalid, 0);
        step();
        check("t1_lat2", out_if.tvalid, 1);
        for (int i = 1; i <= 4; i++) begin
            check("t1_valid", out_if.tvalid, 1);
            check("t1_data", out_if.tdata, i);
            check("t1_last", out_if.tlast, i == 4);
            step();
        end
        check("t1_done", out_if.tvalid, 0);
        check("t1_pkt0", pkt_count, 0);

        // 2: gapped input, gapless output
        send($urandom, 1'b0);
        step();
        send($urandom, 1'b0);
        step();
        send($urandom, 1'b1);
        k = 0;
        while (out_if.tvalid !== 1'b1 && k < 10) begin
            step();
            k++;
        end
        for (int i = 0; i < 3; i++) begin
            check("t2_nogap", out_if.tvalid, 1);
            step();
        end
        check("t2_done", out_if.tvalid, 0);

        // 3: three 2-beat packets held, then toggled ready
        out_if.tready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            send($urandom, 1'b0);
            send($urandom, 1'b1);
        end
        repeat (3) step();
        check("t3_pkt3", pkt_count, 3);
        check("t3_valid", out_if.tvalid, 1);
        k = 0;
        while (exp_q.size() > 0 && k < 60) begin
            out_if.tready = ~out_if.tready;
            step();
            k++;
        end
        check("t3_empty", exp_q.size(), 0);
        check("t3_pkt0", pkt_count, 0);

        // 4: fill with 16-beat packets, then full-rate streaming
        out_if.tready = 1'b0;
        for (int p = 0; p < 5; p++) add_pkt(16);
        pump(80, 100, -1);
        check("t4_full_tready", in_if.tready, 0);
        check("t4_stored", exp_q.size(), DEPTH);
        check("t4_pkt4", pkt_count, 4);
        for (int p = 0; p < 4; p++) add_pkt(16);
        out_if.tready = 1'b1;
        pump(3, 100, -1);
        in_cnt  = 0;
        out_cnt = 0;
        pump(40, 100, -1);
        check("t4_in_rate", in_cnt, 40);
        check("t4_out_rate", out_cnt, 40);
        pump(100, 100, -1);
        drain(200);

        // 5: oversize packet forces cut-through, then normal store-and-forward
        ovs_cnt       = 0;
        out_if.tready = 1'b0;
        add_pkt(100);
        pump(70, 100, -1);
        check("t5_full_tready", in_if.tready, 0);
        check("t5_stored", exp_q.size(), DEPTH);
        check("t5_ovs_pulse", ovs_cnt, 1);
        out_if.tready = 1'b1;
        pump(200, 100, -1);
        check("t5_src_done", src_q.size(), 0);
        drain(200);
        check("t5_ovs_once", ovs_cnt, 1);
        send($urandom, 1'b0);
        check("t5_no_cut", out_if.tvalid, 0);
        send($urandom, 1'b1);
        step();
        check("t5_lat1", out_if.tvalid, 0);
        step();
        check("t5_lat2", out_if.tvalid, 1);
        drain(20);

        // 6: reset with a queued packet and a partial one
        out_if.tready = 1'b0;
        for (int i = 0; i < 3; i++) send($urandom, i == 2);
        for (int i = 0; i < 5; i++) send($urandom, 1'b0);
        reset = 1'b1;
        step();
        check("t6_tvalid", out_if.tvalid, 0);
        check("t6_pkt", pkt_count, 0);
        check("t6_tready_in", in_if.tready, 0);
        reset = 1'b0;
        out_if.tready = 1'b1;
        send($urandom, 1'b0);
        send($urandom, 1'b1);
        step();
        check("t6_lat1", out_if.tvalid, 0);
        step();
        check("t6_lat2", out_if.tvalid, 1);
        drain(20);

        // Random packets, random valid/ready
        for (int i = 0; i < 600; i++) begin
            if (src_q.size() < 4) add_pkt(int'($urandom_range(24, 1)));
            pump(1, 70, 60);
        end
        pump(300, 100, 100);
        check("rnd_src_done", src_q.size(), 0);
        drain(200);
        check("rnd_pkt0", pkt_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
- Store-and-forward AXI-stream packet FIFO, instantiated directly downstream of the two-input stream mux (input = mux axis_out_*).
- Buffers each packet completely and only presents it downstream once its tlast beat has been written. The downstream consumer therefore never sees a packet stall mid-flight because an upstream source is slow.
- Oversize packets (longer than DEPTH beats) use a forced cut-through release, so the FIFO cannot deadlock.

Parameters:
- DW, 512, data width in bits for tdata (in and out).
- DEPTH, 64, buffer depth in beats. Must be a power of 2 and >= 4.
- AW, $clog2(DEPTH), derived pointer width. Not to be overridden.

Ports:
- clk  input  1  sole clock. All logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- axis_in_tdata  input  DW  input beat data.
- axis_in_tlast  input  1  input end-of-packet.
- axis_in_tvalid  input  1  input beat valid.
- axis_in_tready  output  1  FIFO can accept a beat.
- axis_out_tdata  output  DW  output beat data (registered).
- axis_out_tlast  output  1  output end-of-packet (registered).
- axis_out_tvalid  output  1  output beat valid (registered).
- axis_out_tready  input  1  downstream accepts the beat.
- pkt_count  output  AW+1  number of complete packets stored, including the one in the output register.
- oversize  output  1  one-cycle pulse when forced release starts.

Behaviour:
- Reset (synchronous, while reset=1 at a clk edge):
  - Write and read pointers = 0; beat count = 0; pkt_count = 0.
  - axis_out_tvalid = 0, axis_out_tlast = 0, axis_out_tdata = 0.
  - oversize = 0; forced-release flag cleared.
  - axis_in_tready = 0 while reset is high.
  - Any partially written packet is discarded.
- Storage: DEPTH x (DW+1) memory holding tdata and tlast, with a synchronous read. Beat count covers memory plus the output register, range 0..DEPTH.
- Write side:
  - axis_in_tready = 1 when count < DEPTH and not in reset. It is a registered signal, not combinational from axis_out_tready.
  - A beat is written on axis_in_tvalid & axis_in_tready. The write pointer wraps modulo DEPTH.
  - pkt_count increments when a tlast beat is written.
- Read eligibility: the memory head may be fetched when memory is non-empty and either pkt_count > 0 or the forced flag is set.
- Read side:
  - Two-stage path: memory read, then the output register.
  - The output register loads when empty, or when it is being consumed in the same cycle (no bubble between beats).
  - Latency: with the FIFO idle, axis_out_tvalid rises exactly 2 clk cycles after the cycle in which the first packet's tlast beat is accepted. Earlier beats are not visible before that.
  - AXI rule: once axis_out_tvalid=1, tdata, tlast and tvalid hold until axis_out_tready=1.
  - Steady streaming sustains 1 beat per clk in and out simultaneously.
- pkt_count:
  - Decrements when a tlast beat leaves the output (axis_out_tvalid & axis_out_tready & axis_out_tlast).
  - Simultaneous tlast write and tlast read in the same cycle leaves pkt_count unchanged.
- Forced release (oversize):
  - Entry condition: count == DEPTH and pkt_count == 0. The flag is set, and oversize pulses for 1 cycle.
  - While the flag is set, the read side treats the memory as releasable and streams beats as they become available, i.e. cut-through.
  - The flag clears on the cycle the tlast beat of that packet leaves the output.
  - While forced, tvalid may drop between beats, but only after a completed handshake.
- Full: axis_in_tready = 0 when count == DEPTH; input is held off with no loss.
- Empty: axis_out_tvalid = 0 and no read is issued. No underflow is possible.
- Zero-beat packets do not exist. A single-beat packet (tlast on the first beat) is legal.

Test Plan:
1. Single 4-beat packet (tdata 0x1..0x4, tlast on 0x4), axis_out_tready=1 -> no out tvalid before tlast is accepted; tvalid rises exactly 2 cycles after; 4 consecutive beats 0x1..0x4, tlast only on 0x4; pkt_count goes 0->1->0.
2. Input 3-beat packet with tvalid gaps (1 idle cycle between beats) -> output emits all 3 beats back-to-back with no gaps.
3. Three 2-beat packets written with axis_out_tready=0 -> pkt_count=3, data held stable. Then toggle tready 1/0 each cycle -> 6 beats out in order, each beat stable until accepted, pkt_count ends at 0.
4. Fill the FIFO (DEPTH=64): 16-beat packets with tready=0 -> axis_in_tready=0 at 64 beats, no beat lost. Then release with continuous in+out -> 1 beat/cycle, simultaneous tlast in/out leaves pkt_count steady.
5. Oversize: 100-beat packet with tready=0 -> oversize pulses once when count hits 64; after tready=1, all 100 beats out in order with tlast on beat 100; flag clears; a following 2-beat packet behaves normally (store-and-forward).
6. Reset mid-packet: assert reset after 5 of 8 input beats with a complete packet still queued -> next cycle tvalid=0, pkt_count=0, tready_in=0. After reset drops, a new 2-beat packet passes with the normal 2-cycle latency and none of the old data appears.
